button_pulse_conditioner: RTL

//  Input-side partner of the 2-bit switch capture register.
//  - Turns a raw, bouncy, asynchronous push-button into clean one-cycle strobes in the clk domain.
//  - Downstream registers use press_pulse as a capture enable instead of clocking directly off a button.
//  - One instance per button; the top level instantiates two (capture, clear).

---
 rtl/btn_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/button_pulse_conditioner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning blocks.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 50_000;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the
// level both flops take during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same edge and the chain really is two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces a raw push-button into a clean level plus one-cycle press/release
// strobes. Define BTN_AUTOREPEAT_EN to add held-button auto-repeat strobes.
module button_pulse_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE_RAW = (BTN_ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_pulse_conditioner: DEBOUNCE_CYCLES >= 2 and repeat timings >= 1 required");
  end

  logic raw_sync;
  logic act;

  sync_2ff #(.RST_VAL(IDLE_RAW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (raw_sync)
  );

  assign act = raw_sync ^ IDLE_RAW;

  btn_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          press_next, release_next;
  logic          rep_fire;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (act) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!act) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int             RCW       = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                   REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic [RCW-1:0] rep_cnt, rep_cnt_next;
  logic           repeating, repeating_next;

  // The first strobe waits REPEAT_DELAY; once repeating, each waits REPEAT_PERIOD.
  always_comb begin
    rep_cnt_next   = '0;
    repeating_next = 1'b0;
    rep_fire       = 1'b0;
    if (state == PRESSED && act) begin
      repeating_next = repeating;
      if (rep_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
        rep_fire       = 1'b1;
        repeating_next = 1'b1;
      end else begin
        rep_cnt_next = rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_next;
      repeating <= repeating_next;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      btn_level     <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      press_pulse   <= press_next | rep_fire;
      release_pulse <= release_next;
    end
  end

endmodule
